gray_ptr_fifo: RTL and testbench
================================

# gray_ptr_fifo

Single-clock, first-word-fall-through FIFO whose read and write pointers are held and published as (ADDR_W+1)-bit Gray code, with full/empty derived directly from the Gray pointers. It sits downstream of the user-side Gray pointer generation in user_fifo. It buffers producer data behind a valid/ready handshake and exports its Gray pointers for later clock-domain-crossing reuse.

## Interface
- DATA_W, 8, payload width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (16 by default)

- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous, active-low reset
- in_data  input  DATA_W  write payload
- in_valid  input  1  producer has data
- in_ready  output  1  FIFO can accept; push when in_valid && in_ready
- out_data  output  DATA_W  head entry, valid when out_valid
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer takes head; pop when out_valid && out_ready
- wr_ptr_gray  output  ADDR_W+1  Gray-coded write pointer
- rd_ptr_gray  output  ADDR_W+1  Gray-coded read pointer
- count  output  ADDR_W+1  occupancy, 0..2**ADDR_W

## Operation
- State per side: binary pointer wr_bin/rd_bin (ADDR_W+1 bits) and registered Gray copy wr_ptr_gray/rd_ptr_gray.
- Gray copy update: the Gray register takes gray(next_bin) = next_bin ^ (next_bin >> 1) in the same edge as the binary pointer. The Gray pointer therefore always equals gray(current binary pointer), with no one-cycle lag.
- Storage: 2**ADDR_W x DATA_W register array. The write address is wr_bin[ADDR_W-1:0] and the read address is rd_bin[ADDR_W-1:0].
- Empty: wr_ptr_gray == rd_ptr_gray.
- Full: wr_ptr_gray == {~rd_ptr_gray[ADDR_W:ADDR_W-1], rd_ptr_gray[ADDR_W-2:0]}.
  - For ADDR_W = 1, full is wr_ptr_gray == ~rd_ptr_gray.
- Handshake outputs: in_ready = !full and out_valid = !empty. Both are combinational from the registered pointers only, so neither depends on in_valid or out_ready.
- Push: in_valid && in_ready writes in_data to mem[wr addr] and increments wr_bin.
- Pop: out_valid && out_ready increments rd_bin.
- out_data: combinational read mem[rd_bin[ADDR_W-1:0]] (show-ahead).
- count: (wr_bin - rd_bin) modulo 2**(ADDR_W+1). It is registered-derived and reads 2**ADDR_W when full.
- Wrap-around: pointers roll from 2**(ADDR_W+1)-1 to 0 naturally. The Gray value rolls from gray(31) = 5'b10000 to 5'b00000 (for ADDR_W = 4), one bit changing.
- Simultaneous push and pop:
  - Non-empty and non-full: both pointers advance and count is unchanged.
  - Empty: only the push occurs. There is no bypass, because out_valid = 0.
  - Full: only the pop occurs, because in_ready = 0.
- Input data is ignored when in_valid = 0 or in_ready = 0. No error or overflow flag exists; the handshake makes overflow and underflow impossible.

## Timing
- Reset (resetn low, asynchronous, takes effect immediately):
  - wr_bin, rd_bin, wr_ptr_gray, rd_ptr_gray and count = 0.
  - Memory cleared to 0, so out_data = 0.
  - out_valid = 0 and in_ready = 1.
- Reset release: resetn is deasserted synchronously by the system; the first push is accepted on the first rising edge with resetn high.
- Reset mid-operation: all contents are discarded and the state above returns asynchronously. Handshakes in flight at that edge are not completed.
- Write-to-read latency: a push at edge N gives out_valid = 1 and out_data = that word after edge N, i.e. during cycle N+1.
- A pop at edge N presents the next entry, or out_valid = 0, after edge N.
- in_ready deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after the first pop from full.
- Pointer outputs change only on clk edges or reset.

## Test plan
- Reset: drive resetn low mid-stream with count = 5 → out_valid = 0, in_ready = 1, count = 0, wr_ptr_gray = 0 and out_data = 0, without waiting for a clock edge.
- Fill and drain: push 0x00..0x0F with out_ready = 0 → after 16 pushes count = 16, in_ready = 0 and wr_ptr_gray = 5'b11000. A 17th attempt with in_valid = 1 is not accepted. Then drain with out_ready = 1 → 0x00..0x0F in order, then out_valid = 0.
- Latency: push 0xA5 into an empty FIFO at edge N → out_valid = 1 and out_data = 0xA5 in cycle N+1, not N.
- Simultaneous push and pop:
  - With count = 3, 10 cycles of push+pop → count stays 3 and data order is preserved.
  - When empty, push+pop in one cycle → count = 1, nothing is popped.
  - When full, push+pop → count = 15 and the push is rejected.
- Wrap: stream 100 words with random valid/ready → output sequence equals the input sequence. Each pointer passes 31→0 at least three times, wr_ptr_gray changes exactly one bit per increment, and gray(31) = 5'b10000 → 5'b00000.
- Parameters: DATA_W = 32, ADDR_W = 1 → full at count = 2 (wr_ptr_gray = ~rd_ptr_gray) and empty/full behaviour otherwise identical.

Source files
------------

// File: rtl/gray_ptr_fifo.sv
// gray_ptr_fifo: single-clock show-ahead FIFO whose read/write pointers are
// kept in binary for addressing and mirrored as registered (ADDR_W+1)-bit
// Gray code. Full/empty come straight from the Gray copies so the same
// pointers can later be handed across a clock domain without re-encoding.
module gray_ptr_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // producer side
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  // consumer side
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  // published pointers and occupancy
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;

  // Binary to reflected Gray code.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Pointer state: binary for addressing, Gray for status and export.
  logic [PTR_W-1:0]  wr_bin_q, wr_bin_d;
  logic [PTR_W-1:0]  rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0]  wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0]  rd_gray_q, rd_gray_d;

  // Storage and per-entry write enables.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  wr_en;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = wr_bin_q[ADDR_W-1:0];
  assign rd_addr = rd_bin_q[ADDR_W-1:0];

  // Empty when the Gray pointers match exactly.
  assign empty = (wr_gray_q == rd_gray_q);

  // Full when the write pointer is exactly one lap ahead. In Gray code a
  // one-lap offset flips the two most significant bits; with a 2-bit pointer
  // that is the whole word.
  generate
    if (ADDR_W == 1) begin : g_full_narrow
      assign full = (wr_gray_q == ~rd_gray_q);
    end else begin : g_full_wide
      assign full = (wr_gray_q == {~rd_gray_q[ADDR_W -: 2], rd_gray_q[ADDR_W-2:0]});
    end
  endgenerate

  // Handshakes depend only on registered pointers, never on the partner's
  // valid/ready, so there is no combinational path through the FIFO.
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy: modular difference of the binary pointers; reads DEPTH when full.
  assign count = wr_bin_q - rd_bin_q;

  // Show-ahead read of the head entry.
  assign out_data = mem_q[rd_addr];

  // Published Gray pointers are the registered copies themselves.
  assign wr_ptr_gray = wr_gray_q;
  assign rd_ptr_gray = rd_gray_q;

  // One decoded write strobe per storage entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_addr == ADDR_W'(gi));
    end
  endgenerate

  // Next-state pointers; the Gray copy is derived from the next binary
  // value so it lands on the same edge with no lag.
  always_comb begin
    wr_bin_d  = wr_bin_q + PTR_W'(push);
    rd_bin_d  = rd_bin_q + PTR_W'(pop);
    wr_gray_d = bin2gray(wr_bin_d);
    rd_gray_d = bin2gray(rd_bin_d);
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_bin_q  <= '0;
      rd_bin_q  <= '0;
      wr_gray_q <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      rd_bin_q  <= rd_bin_d;
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  // Storage array; cleared on reset so out_data reads zero when empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_q[i] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Bench for gray_ptr_fifo: directed stimulus with a reference occupancy /
// pointer model, plus a scoreboard queue drained by an independent monitor.
module tb_gray_ptr_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW:0]   count;

  // Narrow instance: DATA_W = 32, ADDR_W = 1.
  logic [31:0] s_in_data, s_out_data;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [1:0]  s_wr_g, s_rd_g, s_count;

  always #5 clk = ~clk;

  gray_ptr_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count)
  );

  gray_ptr_fifo #(.DATA_W(32), .ADDR_W(1)) dut_s (
    .clk(clk), .resetn(resetn),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .wr_ptr_gray(s_wr_g), .rd_ptr_gray(s_rd_g), .count(s_count)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            model_cnt;
  logic [AW:0]   model_wr, model_rd;
  logic [AW:0]   prev_wr_g, prev_rd_g;
  int            wr_wraps = 0;
  int            rd_wraps = 0;

  function automatic logic [AW:0] gray5(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: just before each rising edge, a visible head that the consumer
  // takes must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (resetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h required=none", out_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          $display("pop  data=%02h expected=%02h", out_data, e);
          check("pop_data", out_data, e);
        end
      end
    end
  end

  // One clock cycle: check visible state against the model, then drive.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, output bit acc);
    bit pu, po;
    @(negedge clk);
    #1;
    check("count", count, model_cnt);
    check("in_ready", in_ready, model_cnt < DEPTH);
    check("out_valid", out_valid, model_cnt > 0);
    check("wr_gray", wr_ptr_gray, gray5(model_wr));
    check("rd_gray", rd_ptr_gray, gray5(model_rd));
    if (wr_ptr_gray != prev_wr_g) begin
      check("wr_gray_1bit", $countones(wr_ptr_gray ^ prev_wr_g), 1);
      if (prev_wr_g == 5'b10000 && wr_ptr_gray == 5'b00000) wr_wraps++;
    end
    if (rd_ptr_gray != prev_rd_g) begin
      check("rd_gray_1bit", $countones(rd_ptr_gray ^ prev_rd_g), 1);
      if (prev_rd_g == 5'b10000 && rd_ptr_gray == 5'b00000) rd_wraps++;
    end
    prev_wr_g = wr_ptr_gray;
    prev_rd_g = rd_ptr_gray;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    pu = v && (model_cnt < DEPTH);
    po = r && (model_cnt > 0);
    if (pu) begin
      exp_q.push_back(d);
      $display("push data=%02h count_before=%0d", d, model_cnt);
    end
    model_cnt = model_cnt + int'(pu) - int'(po);
    model_wr  = model_wr + 5'(pu);
    model_rd  = model_rd + 5'(po);
    acc = pu;
  endtask

  task automatic reset_dut();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    resetn    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    resetn    = 1'b1;
    model_cnt = 0;
    model_wr  = '0;
    model_rd  = '0;
    prev_wr_g = '0;
    prev_rd_g = '0;
    exp_q.delete();
  endtask

  task automatic drain();
    bit a;
    while (model_cnt > 0) cycle(1'b0, 8'h00, 1'b1, a);
    cycle(1'b0, 8'h00, 1'b0, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int pushed;
    s_in_data = '0; s_in_valid = 0; s_out_ready = 0;
    reset_dut();

    // Asynchronous reset with five entries held.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, acc);
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    check("pre_reset_count", count, 5);
    resetn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_wr_gray", wr_ptr_gray, 0);
    check("rst_out_data", out_data, 0);
    reset_dut();

    // Fill 0x00..0x0F, attempt a 17th push, then drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, acc);
    cycle(1'b1, 8'hEE, 1'b0, acc);
    check("full_wr_gray", wr_ptr_gray, 5'b11000);
    check("push17_rejected", acc, 0);
    drain();

    // Latency: word visible one cycle after its push edge.
    cycle(1'b1, 8'hA5, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    check("latency_data", out_data, 8'hA5);
    drain();

    // Push+pop at count 3 for 10 cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, acc);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h50 + i), 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    check("steady_count", count, 3);
    drain();

    // Push+pop when empty: only the push happens.
    cycle(1'b1, 8'h77, 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    check("empty_pp_count", count, 1);

    // Push+pop when full: only the pop happens.
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, acc);
    cycle(1'b1, 8'hFE, 1'b1, acc);
    check("full_pp_push", acc, 0);
    cycle(1'b0, 8'h00, 1'b0, acc);
    check("full_pp_count", count, 15);
    drain();

    // Stream 100 words with a fixed valid/ready pattern.
    pushed = 0;
    for (int i = 0; i < 600 && pushed < 100; i++) begin
      cycle((i % 3) != 2 && pushed < 100, 8'(pushed), (i % 4) != 3, acc);
      if (acc) pushed++;
    end
    check("stream_pushed", pushed, 100);
    drain();
    check("scoreboard_empty", exp_q.size(), 0);
    check("wr_wraps_ge3", wr_wraps >= 3, 1);
    check("rd_wraps_ge3", rd_wraps >= 3, 1);

    // Narrow instance: full at two entries.
    @(negedge clk); #1;
    s_in_valid = 1; s_in_data = 32'hDEADBEEF;
    @(negedge clk); #1;
    check("s_count1", s_count, 1);
    s_in_data = 32'h12345678;
    @(negedge clk); #1;
    check("s_count2", s_count, 2);
    check("s_in_ready_full", s_in_ready, 0);
    check("s_wr_gray", s_wr_g, 2'b11);
    check("s_rd_gray", s_rd_g, 2'b00);
    check("s_head", s_out_data, 32'hDEADBEEF);
    s_in_data = 32'hCAFEF00D;
    @(negedge clk); #1;
    check("s_count_rejected", s_count, 2);
    s_in_valid = 0; s_out_ready = 1;
    @(negedge clk); #1;
    check("s_count_pop", s_count, 1);
    check("s_in_ready_again", s_in_ready, 1);
    check("s_second", s_out_data, 32'h12345678);
    @(negedge clk); #1;
    check("s_empty", s_out_valid, 0);
    check("s_rd_gray_end", s_rd_g, 2'b11);
    s_out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
